// File: rtl/pad_cond_pkg.sv
// pad_cond_pkg
//   Shared types and defaults for the pad input conditioner.
//   edge_mode_e selects which filtered edges set a pad's sticky status bit:
//   bit 0 = rising edges, bit 1 = falling edges.
package pad_cond_pkg;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_CNT_W       = 8;

  typedef enum logic [1:0] {
    EDGE_NONE = 2'b00,
    EDGE_RISE = 2'b01,
    EDGE_FALL = 2'b10,
    EDGE_BOTH = 2'b11
  } edge_mode_e;

  // True when the mode lets a rising edge set status.
  function automatic logic mode_rise(input edge_mode_e m);
    return (m == EDGE_RISE) || (m == EDGE_BOTH);
  endfunction

  // True when the mode lets a falling edge set status.
  function automatic logic mode_fall(input edge_mode_e m);
    return (m == EDGE_FALL) || (m == EDGE_BOTH);
  endfunction

endpackage

// File: rtl/pad_input_filter.sv
// pad_input_filter
//   One conditioned pad channel: synchronizer chain, glitch/debounce filter,
//   filtered level and edge detection.
// Ports
//   clk_i, rst_ni      core clock, async active-low reset
//   pad_i              raw asynchronous pad level
//   filter_en_i        filter enable (0 = bypass)
//   filter_cycles_i    stability threshold F (0 = bypass)
//   val_o              synchronized, filtered level
//   rise_o / fall_o    one-cycle pulse on the first cycle of a new level
module pad_input_filter #(
  parameter int   SYNC_STAGES = 2,   // legal range 2..4
  parameter int   CNT_W       = 8,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             pad_i,
  input  logic             filter_en_i,
  input  logic [CNT_W-1:0] filter_cycles_i,
  output logic             val_o,
  output logic             rise_o,
  output logic             fall_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   val_q, val_d;
  logic                   hist_q;
  logic                   bypass;

  // Plain flop chain: nothing may sit between the stages.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pad_i};
    end
  end

  assign sync_s = sync_q[SYNC_STAGES-1];
  assign bypass = !filter_en_i || (filter_cycles_i == '0);

  // The level changes only once the synchronized input has disagreed with it
  // for F consecutive cycles. The >= compare means a threshold lowered below
  // the running count takes effect on the next mismatching cycle.
  always_comb begin
    val_d = val_q;
    cnt_d = cnt_q;
    if (bypass) begin
      val_d = sync_s;
      cnt_d = '0;
    end else if (sync_s == val_q) begin
      cnt_d = '0;
    end else if (cnt_q >= (filter_cycles_i - CNT_W'(1))) begin
      val_d = sync_s;
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      val_q  <= RESET_VAL;
      hist_q <= RESET_VAL;
    end else begin
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      hist_q <= val_q;
    end
  end

  // History resets to the same value as the level, so reset release is silent.
  assign val_o  = val_q;
  assign rise_o = val_q & ~hist_q;
  assign fall_o = ~val_q & hist_q;

endmodule

// File: rtl/pad_input_conditioner.sv
// pad_input_conditioner
//   Conditions NUM_PADS raw input-pad levels: synchronize, filter, detect
//   edges, keep sticky per-pad event status and raise one level interrupt.
// Ports
//   clk_i, rst_ni      core clock, async active-low reset
//   pad_in_i           raw pad levels (asynchronous)
//   filter_en_i        per-pad filter enable
//   filter_cycles_i    shared stability threshold F
//   edge_mode_i        per-pad edge_mode_e, pad k at [2k+1:2k]
//   irq_en_i           per-pad interrupt mask
//   status_clr_i       one-cycle clear per status bit
//   pad_val_o          filtered levels
//   rise_o / fall_o    one-cycle edge pulses
//   status_o           sticky event flags
//   irq_o              OR of (status_o & irq_en_i)
module pad_input_conditioner
  import pad_cond_pkg::*;
#(
  parameter int   NUM_PADS    = 4,
  parameter int   SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int   CNT_W       = DEF_CNT_W,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic [0:0]          clk_i,
  input  logic                rst_ni,
  input  logic [NUM_PADS-1:0] pad_in_i,
  input  logic [NUM_PADS-1:0] filter_en_i,
  input  logic [CNT_W-1:0]    filter_cycles_i,
  input  logic [2*NUM_PADS-1:0] edge_mode_i,
  input  logic [NUM_PADS-1:0] irq_en_i,
  input  logic [NUM_PADS-1:0] status_clr_i,
  output logic [NUM_PADS-1:0] pad_val_o,
  output logic [NUM_PADS-1:0] rise_o,
  output logic [NUM_PADS-1:0] fall_o,
  output logic [NUM_PADS-1:0] status_o,
  output logic                irq_o
);

  logic [NUM_PADS-1:0] status_q, status_d;
  logic [NUM_PADS-1:0] set_evt;

  for (genvar k = 0; k < NUM_PADS; k++) begin : g_pad
    pad_input_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .CNT_W       (CNT_W),
      .RESET_VAL   (RESET_VAL)
    ) u_filter (
      .clk_i           (clk_i[0]),
      .rst_ni          (rst_ni),
      .pad_i           (pad_in_i[k]),
      .filter_en_i     (filter_en_i[k]),
      .filter_cycles_i (filter_cycles_i),
      .val_o           (pad_val_o[k]),
      .rise_o          (rise_o[k]),
      .fall_o          (fall_o[k])
    );
  end

  // A new event wins over a same-cycle clear so no edge is ever lost.
  always_comb begin
    set_evt  = '0;
    status_d = status_q;
    for (int k = 0; k < NUM_PADS; k++) begin
      set_evt[k] = (rise_o[k] & mode_rise(edge_mode_e'(edge_mode_i[2*k +: 2]))) |
                   (fall_o[k] & mode_fall(edge_mode_e'(edge_mode_i[2*k +: 2])));
      if (set_evt[k]) begin
        status_d[k] = 1'b1;
      end else if (status_clr_i[k]) begin
        status_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i[0] or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q <= '0;
    end else begin
      status_q <= status_d;
    end
  end

  assign status_o = status_q;
  // Mask applies only here, so unmasking a pending event raises irq at once.
  assign irq_o    = |(status_q & irq_en_i);

endmodule

// File: doc/pad_input_conditioner.md
Name: pad_input_conditioner

Overview:
- Sits directly downstream of the input pad cells. Consumes their raw, asynchronous core-side outputs (pad_out_o of each input pad).
- Per pad: synchronizes into the clk_i domain, applies a programmable glitch/debounce filter, and detects rising and falling edges.
- Keeps sticky per-pad event status and produces one level interrupt for the peripheral/interrupt controller.
- Configuration comes from a register block and is supplied here as static-ish inputs.

Parameters:
- NUM_PADS, 4, number of conditioned input pads.
- SYNC_STAGES, 2, synchronizer flop depth; legal range 2..4.
- CNT_W, 8, width of the filter threshold and of each filter counter.
- RESET_VAL, 1'b0, reset value of synchronizer flops, filtered value and edge-history flop.

Ports:
- clk_i  in  1  core clock.
- rst_ni  in  1  async active-low reset.
- pad_in_i  in  NUM_PADS  raw pad values from input pad cells (asynchronous).
- filter_en_i  in  NUM_PADS  per-pad filter enable.
- filter_cycles_i  in  CNT_W  stability threshold F, shared by all pads.
- edge_mode_i  in  2*NUM_PADS  per-pad edge select, pad k at bits [2k+1:2k], encoded as edge_mode_e.
- irq_en_i  in  NUM_PADS  per-pad interrupt mask.
- status_clr_i  in  NUM_PADS  one-cycle clear pulse per status bit.
- pad_val_o  out  NUM_PADS  synchronized, filtered pad level.
- rise_o  out  NUM_PADS  one-cycle rising-edge pulse.
- fall_o  out  NUM_PADS  one-cycle falling-edge pulse.
- status_o  out  NUM_PADS  sticky event flags.
- irq_o  out  1  OR of (status_o & irq_en_i).

Behaviour:
- Reset (async, rst_ni=0):
  - Sync flops, pad_val_o and edge history = RESET_VAL.
  - Filter counters = 0; status_o = 0.
  - rise_o, fall_o and irq_o = 0.
- Release of reset produces no edge pulse, because pad_val_o and its history are equal.
- Synchronizer: SYNC_STAGES-deep flop chain per pad, output s[k]. No logic is placed between the stages.
- Filter, per pad, bypass mode (filter_en_i[k]=0 or F=0): pad_val_o[k] <= s[k] every cycle.
- Filter, per pad, filtered mode:
  - If s[k]==pad_val_o[k]: counter cleared.
  - Else, if counter >= F-1: pad_val_o[k] <= s[k] and counter cleared.
  - Else: counter increments. The counter saturates at all-ones and never wraps.
  - pad_val_o[k] therefore changes only after s[k] has differed for F consecutive cycles. Any return to the old value restarts the count.
  - F=1 is equivalent to bypass.
- Latency from a pad_in_i change to pad_val_o: SYNC_STAGES + max(F,1) cycles (plus up to 1 cycle of sampling uncertainty).
- Threshold change mid-count: the >= comparison applies. Lowering F below the current count updates pad_val_o on the next mismatching cycle.
- Toggling filter_en_i mid-count: the counter is cleared whenever the pad is in bypass mode.
- Edges:
  - Edge history register h[k] <= pad_val_o[k].
  - rise_o[k] = pad_val_o[k] & ~h[k].
  - fall_o[k] = ~pad_val_o[k] & h[k].
  - Each is high exactly for the first cycle of the new level.
- Status, per pad:
  - set = (rise_o[k] & mode[0]) | (fall_o[k] & mode[1]), with mode encoded NONE=00, RISE=01, FALL=10, BOTH=11.
  - status_o[k] <= set ? 1 : (status_clr_i[k] ? 0 : status_o[k]). When set and clear occur in the same cycle, set wins.
- irq_o: combinational from the status register and irq_en_i; no additional latency.
- Masking does not block status setting. Enabling a mask bit while status is already 1 raises irq_o in the same cycle.

Decomposition:
- Package pad_cond_pkg:
  - edge_mode_e (NONE, RISE, FALL, BOTH).
  - Default SYNC_STAGES and CNT_W constants.
- Sub-module pad_input_filter: one channel, containing the synchronizer chain, filter counter, pad_val and edge history, with outputs val/rise/fall.
- Top level: generates NUM_PADS instances of pad_input_filter and holds the status/irq logic.

Test Plan:
1. Reset values: hold rst_ni=0, toggle pad_in_i -> all outputs 0 (RESET_VAL=0); release reset with pad_in_i=0 -> no rise/fall pulse.
2. Bypass latency: filter_en_i=0, pad_in_i[0] 0->1 -> pad_val_o[0] rises 3 cycles later (SYNC_STAGES=2); rise_o[0] high 1 cycle; status_o[0]=1 with mode RISE.
3. Glitch rejection: filter_en_i=1, F=5, pulses of 4 cycles high -> pad_val_o stays 0; 5-cycle high pulse -> pad_val_o rises 7 cycles after the input edge.
4. Edge modes: pad 1 mode FALL, pad 2 mode BOTH, drive a 1->0->1 sequence -> status_o[1] set only by the fall; status_o[2] set by both edges; pad with mode NONE never sets.
5. Status/IRQ: status_o[3]=1 with irq_en_i[3]=0 -> irq_o=0; set irq_en_i[3] -> irq_o=1 the same cycle; status_clr_i[3] pulse -> irq_o=0 next cycle; clear pulse coinciding with a new edge -> status stays 1.
6. Async reset mid-count: F=200 with the counter at 100 -> rst_ni low for a partial cycle clears counter and status; after release the input must be stable for a full 200 cycles to update pad_val_o.
